// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read-port bundle between the async FIFO (master) and the UART TX drain (slave).
interface uart_tx_fifo_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  FIFO_EMPTY;
  logic [DATA_WIDTH-1:0] FIFO_RD_DATA;
  logic                  FIFO_R_INC;

  modport master (
    output FIFO_EMPTY,
    output FIFO_RD_DATA,
    input  FIFO_R_INC
  );

  modport slave (
    input  FIFO_EMPTY,
    input  FIFO_RD_DATA,
    output FIFO_R_INC
  );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART TX serialiser: pops bytes from the FIFO and sends start, LSB-first data,
// optional parity and stop, one bit per TX clock; all outputs come straight from flops.
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  uart_tx_fifo_drain_if.slave          fifo,
  input  logic                         PAR_EN,
  input  logic                         PAR_TYP,
  output logic                         TX_OUT,
  output logic                         BUSY
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_en_q, par_en_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  rinc_q, rinc_d;
  logic                  load;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      rinc_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      rinc_q    <= rinc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    load      = !fifo.FIFO_EMPTY && (state_q == IDLE || state_q == STOP);

    case (state_q)
      IDLE:   state_d = IDLE;
      START:  state_d = DATA;
      DATA: begin
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_WIDTH - 1))
          state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: state_d = STOP;
      STOP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A load in STOP chains the next frame with no idle gap.
    if (load) begin
      state_d   = START;
      shreg_d   = fifo.FIFO_RD_DATA;
      cnt_d     = '0;
      par_en_d  = PAR_EN;
      par_bit_d = (^fifo.FIFO_RD_DATA) ^ PAR_TYP;
    end

    // Outputs are decoded from the next state so they can be registered.
    tx_d   = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shreg_d[0];
      PARITY: tx_d = par_bit_q;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    rinc_d = (state_d == START);
  end

  assign TX_OUT          = tx_q;
  assign BUSY            = busy_q;
  assign fifo.FIFO_R_INC = rinc_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: frame bit patterns, parity, back-to-back, reset abort.
module tb_uart_tx_fifo_drain;

  logic clk;
  logic rst;
  logic par_en;
  logic par_typ;
  logic tx_out;
  logic busy;
  int   n_cmp;
  int   n_err;

  uart_tx_fifo_drain_if #(.DATA_WIDTH(8)) fif ();

  uart_tx_fifo_drain #(.DATA_WIDTH(8)) dut (
    .CLK     (clk),
    .RST     (rst),
    .fifo    (fif),
    .PAR_EN  (par_en),
    .PAR_TYP (par_typ),
    .TX_OUT  (tx_out),
    .BUSY    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Walks one frame starting at its START cycle; exp bit i is the line level in cycle i.
  // After the START cycle the FIFO shows the next entry (or goes empty).
  task automatic check_frame(input string tag, input logic [15:0] exp, input int n,
                             input bit next_avail, input logic [7:0] next_data,
                             input bit toggle_pt);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s tx[%0d]", tag, i), tx_out, exp[i]);
      check($sformatf("%s busy[%0d]", tag, i), busy, 1'b1);
      check($sformatf("%s rinc[%0d]", tag, i), fif.FIFO_R_INC, (i == 0));
      if (i == 0) begin
        fif.FIFO_EMPTY   = !next_avail;
        fif.FIFO_RD_DATA = next_data;
      end
      if (toggle_pt && i == 3) par_typ = ~par_typ;
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s tx", tag), tx_out, 1'b1);
      check($sformatf("%s busy", tag), busy, 1'b0);
      check($sformatf("%s rinc", tag), fif.FIFO_R_INC, 1'b0);
    end
  endtask

  task automatic present(input logic [7:0] d, input bit pe, input bit pt);
    fif.FIFO_EMPTY   = 1'b0;
    fif.FIFO_RD_DATA = d;
    par_en           = pe;
    par_typ          = pt;
  endtask

  logic [15:0] f_a5;
  logic [15:0] f_07e;
  logic [15:0] f_a5o;
  logic [15:0] f_55;
  logic [15:0] f_0f;

  initial begin
    n_cmp = 0;
    n_err = 0;
    // {stop, [parity], data MSB..LSB, start}: bit 0 goes on the line first.
    f_a5  = 16'(10'b1_1010_0101_0);
    f_07e = 16'(11'b1_1_0000_0111_0);
    f_a5o = 16'(11'b1_1_1010_0101_0);
    f_55  = 16'(10'b1_0101_0101_0);
    f_0f  = 16'(10'b1_0000_1111_0);

    rst              = 1'b0;
    fif.FIFO_EMPTY   = 1'b1;
    fif.FIFO_RD_DATA = 8'h00;
    par_en           = 1'b0;
    par_typ          = 1'b0;
    #12;
    check("reset tx", tx_out, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset rinc", fif.FIFO_R_INC, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Single byte, no parity
    check_idle("pre-load", 4);
    present(8'hA5, 1'b0, 1'b0);
    check_frame("a5", f_a5, 10, 1'b0, 8'h00, 1'b0);
    check_idle("post-a5", 3);

    // Even parity
    present(8'h07, 1'b1, 1'b0);
    check_frame("07even", f_07e, 11, 1'b0, 8'h00, 1'b0);
    check_idle("post-07", 2);

    // Odd parity, PAR_TYP toggled during DATA must not matter
    present(8'hA5, 1'b1, 1'b1);
    check_frame("a5odd", f_a5o, 11, 1'b0, 8'h00, 1'b1);
    check_idle("post-a5odd", 2);

    // Back-to-back
    present(8'h55, 1'b0, 1'b0);
    check_frame("b2b55", f_55, 10, 1'b1, 8'h0F, 1'b0);
    check_frame("b2b0f", f_0f, 10, 1'b0, 8'h00, 1'b0);
    check_idle("post-b2b", 3);

    // Reset during the 4th data bit (A5 bit 3 = 0)
    present(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i == 0) fif.FIFO_EMPTY = 1'b1;
    end
    check("pre-abort tx", tx_out, 1'b0);
    check("pre-abort busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("abort tx", tx_out, 1'b1);
    check("abort busy", busy, 1'b0);
    check("abort rinc", fif.FIFO_R_INC, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    check_idle("post-reset", 12);

    // Empty hold
    check_idle("empty-hold", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
